// File: rtl/comparator_stim_gen_pkg.sv
// Shared definitions for the comparator stimulus generator.
// Holds the default field widths and the state encodings used by the
// top-level sequencer and by each pulse channel.
package comparator_stim_gen_pkg;

   localparam int unsigned CNT_W_DEF = 16;  // duration field width (cycles)
   localparam int unsigned PC_W_DEF  = 8;   // pulse-count field width

   // Top-level sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } top_state_t;

   // Per-channel states.
   typedef enum logic [1:0] {
      CH_WAIT = 2'd0,
      CH_HIGH = 2'd1,
      CH_LOW  = 2'd2,
      CH_DONE = 2'd3
   } chan_state_t;

endpackage

// File: rtl/comparator_stim_gen_if.sv
// Control/status bundle of the comparator stimulus generator.
//   master : drives start/abort/lead_sel and the run configuration,
//            observes IA/IB/busy/done/err.
//   slave  : the generator itself.
interface comparator_stim_gen_if
   import comparator_stim_gen_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned PC_W  = PC_W_DEF
);

   logic             start;
   logic             abort;
   logic             lead_sel;
   logic [CNT_W-1:0] high_cycles;
   logic [CNT_W-1:0] low_cycles;
   logic [CNT_W-1:0] offset_cycles;
   logic [PC_W-1:0]  pulse_count;
   logic             IA;
   logic             IB;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, abort, lead_sel, high_cycles, low_cycles, offset_cycles, pulse_count,
      input  IA, IB, busy, done, err
   );

   modport slave (
      input  start, abort, lead_sel, high_cycles, low_cycles, offset_cycles, pulse_count,
      output IA, IB, busy, done, err
   );

endinterface

// File: rtl/comparator_stim_gen_pulse_channel.sv
// One pulse-train channel.
// On go, latches its configuration, waits `delay` cycles, then emits
// `count` pulses of `high` cycles separated by `low` cycles.
//   clock, resetBTN : clock and asynchronous active-low reset
//   go              : one-cycle start strobe (configuration sampled with it)
//   delay/high/low  : wait, high and low durations in cycles
//   count           : number of pulses
//   pulse           : next-cycle channel level (registered by the parent)
//   complete        : channel will be idle from the next cycle on
module pulse_channel
   import comparator_stim_gen_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned PC_W  = PC_W_DEF
) (
   input  logic             clock,
   input  logic             resetBTN,
   input  logic             go,
   input  logic [CNT_W-1:0] delay,
   input  logic [CNT_W-1:0] high,
   input  logic [CNT_W-1:0] low,
   input  logic [PC_W-1:0]  count,
   output logic             pulse,
   output logic             complete
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

   chan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [PC_W-1:0]  left_q, left_d;

   always_ff @(posedge clock or negedge resetBTN) begin
      if (!resetBTN) begin
         state_q <= CH_DONE;
         cnt_q   <= '0;
         high_q  <= '0;
         low_q   <= '0;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         high_q  <= high_d;
         low_q   <= low_d;
         left_q  <= left_d;
      end
   end

   // cnt_q holds the cycles remaining in the current WAIT/HIGH/LOW interval,
   // counting down to 1 and reloading, so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      high_d  = high_q;
      low_d   = low_q;
      left_d  = left_q;
      if (go) begin
         high_d = high;
         low_d  = low;
         left_d = count;
         if (count == '0) begin
            state_d = CH_DONE;
         end else if (delay == '0) begin
            state_d = CH_HIGH;
            cnt_d   = high;
         end else begin
            state_d = CH_WAIT;
            cnt_d   = delay;
         end
      end else begin
         unique case (state_q)
            CH_WAIT: begin
               if (cnt_q == CNT_ONE) begin
                  state_d = CH_HIGH;
                  cnt_d   = high_q;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            CH_HIGH: begin
               if (cnt_q != CNT_ONE) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else if (left_q == PC_ONE) begin
                  // last pulse: trailing low interval is skipped
                  state_d = CH_DONE;
                  left_d  = '0;
                  cnt_d   = '0;
               end else if (low_q == '0) begin
                  // zero low time merges consecutive pulses
                  left_d = left_q - PC_ONE;
                  cnt_d  = high_q;
               end else begin
                  state_d = CH_LOW;
                  left_d  = left_q - PC_ONE;
                  cnt_d   = low_q;
               end
            end
            CH_LOW: begin
               if (cnt_q == CNT_ONE) begin
                  state_d = CH_HIGH;
                  cnt_d   = high_q;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            CH_DONE: begin
               state_d = CH_DONE;
            end
         endcase
      end
   end

   // Next-state decodes; the parent registers them so outputs stay flopped.
   assign pulse    = (state_d == CH_HIGH);
   assign complete = (state_d == CH_DONE);

endmodule

// File: rtl/comparator_stim_gen.sv
// Comparator stimulus generator: produces two offset pulse trains (IA, IB)
// for exercising a phase/edge comparator.
//   clock    : single rising-edge clock
//   resetBTN : asynchronous active-low reset
//   bus      : control/status bundle (start, abort, lead_sel, durations,
//              pulse_count in; IA, IB, busy, done, err out)
module comparator_stim_gen
   import comparator_stim_gen_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned PC_W  = PC_W_DEF
) (
   input  logic                 clock,
   input  logic                 resetBTN,
   comparator_stim_gen_if.slave bus
);

   top_state_t       state_q, state_d;
   logic             accept;
   logic             reject;
   logic [CNT_W-1:0] delay_a, delay_b;
   logic             pulse_a, pulse_b;
   logic             complete_a, complete_b;
   logic             ia_q, ib_q, err_q;

   // abort wins over a simultaneous start; zero high time is rejected
   assign accept = (state_q == ST_IDLE) && bus.start && !bus.abort && (bus.high_cycles != '0);
   assign reject = (state_q == ST_IDLE) && bus.start && !bus.abort && (bus.high_cycles == '0);

   // Channel A always drives IA and channel B drives IB; lead_sel only picks
   // which one receives the offset. Each channel latches its delay on go.
   assign delay_a = bus.lead_sel ? bus.offset_cycles : '0;
   assign delay_b = bus.lead_sel ? '0 : bus.offset_cycles;

   pulse_channel #(.CNT_W(CNT_W), .PC_W(PC_W)) u_chan_a (
      .clock    (clock),
      .resetBTN (resetBTN),
      .go       (accept),
      .delay    (delay_a),
      .high     (bus.high_cycles),
      .low      (bus.low_cycles),
      .count    (bus.pulse_count),
      .pulse    (pulse_a),
      .complete (complete_a)
   );

   pulse_channel #(.CNT_W(CNT_W), .PC_W(PC_W)) u_chan_b (
      .clock    (clock),
      .resetBTN (resetBTN),
      .go       (accept),
      .delay    (delay_b),
      .high     (bus.high_cycles),
      .low      (bus.low_cycles),
      .count    (bus.pulse_count),
      .pulse    (pulse_b),
      .complete (complete_b)
   );

   always_ff @(posedge clock or negedge resetBTN) begin
      if (!resetBTN) begin
         state_q <= ST_IDLE;
         ia_q    <= 1'b0;
         ib_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // Gating on the next state forces the outputs low on abort even if
         // a channel is still mid-sequence; the next go restarts it cleanly.
         ia_q    <= (state_d == ST_RUN) && pulse_a;
         ib_q    <= (state_d == ST_RUN) && pulse_b;
         err_q   <= reject;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.abort)                      state_d = ST_IDLE;
            else if (complete_a && complete_b)  state_d = ST_FINISH;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.IA   = ia_q;
   assign bus.IB   = ib_q;
   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_FINISH);
   assign bus.err  = err_q;

endmodule
